// File: rtl/miriscv_irq_ctrl.sv
// miriscv_irq_ctrl: masks 32 level IRQ lines, picks the lowest pending index and
// sequences trap request, CSR capture and one-hot mret acknowledge back to the device.
module miriscv_irq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] irq_req_i,
    input  logic [31:0] mie_i,
    input  logic        int_ack_i,
    input  logic        mret_i,
    output logic        int_o,
    output logic [31:0] mcause_o,
    output logic [31:0] irq_ret_o,
    output logic        irq_active_o
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE, ACK} state_e;
    state_e      state, state_d;
    logic [4:0]  idx, idx_d, win;
    logic [31:0] pend;
    always_comb begin
        pend = irq_req_i & mie_i;
        win = '0;
        for (int i = 31; i >= 0; i--)
            if (pend[i]) win = 5'(i);
        state_d = state;
        idx_d = idx;
        case (state)
            IDLE: if (|pend) begin
                state_d = REQ;
                idx_d = win;
            end
            REQ:     state_d = int_ack_i ? SERVICE : REQ;
            SERVICE: state_d = mret_i ? ACK : SERVICE;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx <= '0;
            int_o <= 1'b0;
            mcause_o <= '0;
            irq_ret_o <= '0;
            irq_active_o <= 1'b0;
        end else begin
            state <= state_d;
            idx <= idx_d;
            int_o <= state_d == REQ;
            irq_active_o <= state_d == REQ || state_d == SERVICE;
            irq_ret_o <= state_d == ACK ? 32'(1) << idx_d : '0;
            mcause_o <= state_d == REQ ? {1'b1, 26'b0, idx_d} : mcause_o;
        end
    end
endmodule
